fixed_point_arith: RTL and testbench



---
 rtl/fixed_point_pkg.sv | 13 +
 rtl/fixed_point_serial_mul.sv | 91 +++++++++
 rtl/fixed_point_arith.sv | 44 ++++
 tb/tb_fixed_point_arith.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point arithmetic unit.
// Holds the default Q-format widths and the serial multiplier's state encoding.
package fixed_point_pkg;

  localparam int unsigned DefIntegerPartWidth    = 8;
  localparam int unsigned DefFractionalPartWidth = 8;
  localparam int unsigned DefN = DefIntegerPartWidth + DefFractionalPartWidth;

  // Serial multiplier states
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

endpackage

// File: rtl/fixed_point_serial_mul.sv
// Multi-cycle signed fixed-point multiplier, one partial product per clock.
// Ports:
//   clk, rst_n  - clock (rising edge) and asynchronous active-low reset
//   a, b        - signed operands, latched on the start edge
//   mul_start   - request a multiply; only honoured while idle
//   mul_done    - high while idle; mul_result is valid then
//   mul_result  - product truncated (floor) back to the operand Q-format
module fixed_point_serial_mul
  import fixed_point_pkg::*;
#(
  parameter int unsigned INTEGER_PART_WIDTH    = DefIntegerPartWidth,
  parameter int unsigned FRACTIONAL_PART_WIDTH = DefFractionalPartWidth
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] a,
  input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] b,
  input  logic                                          mul_start,
  output logic                                          mul_done,
  output logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] mul_result
);

  localparam int unsigned N    = INTEGER_PART_WIDTH + FRACTIONAL_PART_WIDTH;
  localparam int unsigned F    = FRACTIONAL_PART_WIDTH;
  localparam int unsigned CntW = $clog2(N);
  localparam logic [CntW-1:0] LastStep = CntW'(N - 1);

  logic [0:0]      state_q,  state_d;
  logic [2*N-1:0]  a_sh_q,   a_sh_d;    // sign-extended a, shifted left one place per step
  logic [N-1:0]    b_sh_q,   b_sh_d;    // latched b, shifted right so bit 0 is the current bit
  logic [2*N-1:0]  acc_q,    acc_d;
  logic [CntW-1:0] cnt_q,    cnt_d;
  logic [N-1:0]    result_q, result_d;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (mul_start) begin
          a_sh_d  = {{N{a[N-1]}}, a};
          b_sh_d  = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        // The sign bit of b carries weight -2^(N-1), so its partial product is subtracted.
        if (b_sh_q[0]) begin
          acc_d = (cnt_q == LastStep) ? (acc_q - a_sh_q) : (acc_q + a_sh_q);
        end
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LastStep) begin
          // Arithmetic truncation: dropping low fraction bits floors toward -inf.
          result_d = acc_d[N+F-1:F];
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign mul_done   = (state_q == StIdle);
  assign mul_result = result_q;

endmodule

// File: rtl/fixed_point_arith.sv
// Signed two's-complement fixed-point arithmetic unit, Q(I.F) format.
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset (multiplier only)
//   a, b        - shared signed operands
//   add_result  - a + b, combinational, wraps modulo 2^N
//   sub_result  - a - b, combinational, wraps modulo 2^N
//   mul_start   - multiply request, sampled while mul_done is high
//   mul_done    - multiplier idle / mul_result valid
//   mul_result  - registered a * b, floored and wrapped to Q(I.F)
module fixed_point_arith
  import fixed_point_pkg::*;
#(
  parameter int unsigned INTEGER_PART_WIDTH    = DefIntegerPartWidth,
  parameter int unsigned FRACTIONAL_PART_WIDTH = DefFractionalPartWidth
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] a,
  input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] b,
  output logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] add_result,
  output logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] sub_result,
  input  logic                                          mul_start,
  output logic                                          mul_done,
  output logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] mul_result
);

  // Two's-complement add/sub are sign-agnostic; N-bit results wrap naturally.
  assign add_result = a + b;
  assign sub_result = a - b;

  fixed_point_serial_mul #(
    .INTEGER_PART_WIDTH   (INTEGER_PART_WIDTH),
    .FRACTIONAL_PART_WIDTH(FRACTIONAL_PART_WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .mul_start (mul_start),
    .mul_done  (mul_done),
    .mul_result(mul_result)
  );

endmodule

// File: tb/tb_fixed_point_arith.sv
module tb_fixed_point_arith;

  localparam int N = 16;
  localparam int F = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  a = '0;
  logic [N-1:0]  b = '0;
  logic          mul_start = 1'b0;
  logic [N-1:0]  add_result, sub_result, mul_result;
  logic          mul_done;

  int n_cmp = 0;
  int n_bad = 0;

  fixed_point_arith dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .add_result(add_result),
    .sub_result(sub_result),
    .mul_start (mul_start),
    .mul_done  (mul_done),
    .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  // Real-valued fixed-point product, floored, low N bits kept.
  function automatic logic [N-1:0] fx_mul(input logic [N-1:0] x, input logic [N-1:0] y);
    longint sx, sy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = sx * sy;
    return N'(p >>> F);
  endfunction

  // Behavioural model: a multiply takes N clocks from the start edge, then result appears.
  int           m_left = 0;
  logic [N-1:0] m_a = '0, m_b = '0, m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_res  <= '0;
    end else if (m_left == 0) begin
      if (mul_start) begin
        m_a    <= a;
        m_b    <= b;
        m_left <= N;
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 1) m_res <= fx_mul(m_a, m_b);
    end
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("add_model", add_result, a + b);
    chk("sub_model", sub_result, a - b);
    chk("done_model", {15'd0, mul_done}, {15'd0, (m_left == 0)});
    chk("mul_model", mul_result, m_res);
  end

  // Wait for mul_done high, counting low cycles; bounded.
  task automatic wait_done(output int lo_cycles);
    lo_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mul_done) return;
      lo_cycles++;
    end
    n_cmp++; n_bad++;
    $display("FAIL wait_done: timeout, got busy expected done");
  endtask

  task automatic do_mul(input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic [N-1:0] exp, input bit disturb, input string name);
    int lo;
    @(posedge clk); #2;
    a = x; b = y; mul_start = 1'b1;
    @(posedge clk); #2;
    mul_start = 1'b0;
    lo = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mul_done) break;
      lo++;
      if (disturb && lo == 5) begin
        #1; a = 16'h1234; b = 16'h4321; mul_start = 1'b1;
      end
      if (disturb && lo == 7) begin
        #1; mul_start = 1'b0;
      end
    end
    chk({name, "_lo_cycles"}, 16'(lo), 16'd16);
    chk({name, "_result"}, mul_result, exp);
  endtask

  initial begin
    int lo;
    int hi;
    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_done", {15'd0, mul_done}, 16'd1);
    chk("reset_result", mul_result, 16'h0000);
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Add/sub directed vectors
    a = 16'h0180; b = 16'h0240; #1;
    chk("add_basic", add_result, 16'h03C0);
    chk("sub_basic", sub_result, 16'hFF40);
    a = 16'h7F00; b = 16'h0200; #1;
    chk("add_wrap", add_result, 16'h8100);
    a = 16'h8000; b = 16'h0100; #1;
    chk("sub_wrap", sub_result, 16'h7F00);

    // Multiplies
    do_mul(16'h0180, 16'h0240, 16'h0360, 1'b0, "mul_pos");
    do_mul(16'hFE80, 16'h0200, 16'hFD00, 1'b0, "mul_neg");
    do_mul(16'h0001, 16'hFFFF, 16'hFFFF, 1'b0, "mul_floor");
    do_mul(16'h8000, 16'h8000, 16'h0000, 1'b0, "mul_wrap");
    do_mul(16'h0180, 16'h0240, 16'h0360, 1'b1, "mul_disturb");
    chk("model_pin", fx_mul(16'hFE80, 16'h0200), 16'hFD00);

    // Back-to-back with mul_start held high; operands change mid-op for the second
    @(posedge clk); #2;
    a = 16'h0300; b = 16'h0200; mul_start = 1'b1;
    @(posedge clk); #2;
    a = 16'hFF00; b = 16'h0280;
    wait_done(lo);
    chk("b2b_first_lo", 16'(lo), 16'd16);
    chk("b2b_first_result", mul_result, 16'h0600);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!mul_done) break;
      hi++;
    end
    chk("b2b_idle_cycles", 16'(hi), 16'd0);
    wait_done(lo);
    #1; mul_start = 1'b0;
    chk("b2b_second_lo", 16'(lo), 16'd15);
    chk("b2b_second_result", mul_result, 16'hFD80);

    // Reset mid-multiply
    @(posedge clk); #2;
    a = 16'h0180; b = 16'h0240; mul_start = 1'b1;
    @(posedge clk); #2;
    mul_start = 1'b0;
    repeat (5) @(negedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("rst_mid_done", {15'd0, mul_done}, 16'd1);
    chk("rst_mid_result", mul_result, 16'h0000);
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    do_mul(16'h0240, 16'h0180, 16'h0360, 1'b0, "mul_after_rst");

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
